// File: rtl/write_back.sv
// Commit stage: retires execute results into the GPR/FPR files, owns the
// architectural PC and re-arms fetch once per committed or squashed instruction.
module write_back #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 exec_done,
  input  logic [2:0]           exec_wsel,
  input  logic [31:0]          exec_data,
  input  logic [4:0]           exec_rd,
  input  logic [31:0]          exec_pc_out,
  input  logic                 exec_stall,
  input  logic [4:0]           rs_no,
  input  logic [4:0]           rt_no,
  input  logic                 fmode1,
  input  logic                 fmode2,
  output logic [31:0]          rs_data,
  output logic [31:0]          rt_data,
  output logic [31:0]          pc,
  output logic                 fetch_enable,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t               state_q;
  logic [31:0]          pc_q, pc_d;
  logic                 fetch_q;
  logic [INSTRET_W-1:0] instret_q;
  logic [31:0]          gpr_q [32];
  logic [31:0]          fpr_q [32];
  logic                 reg_we;

  // A squash always redirects; otherwise the redirect bit picks target vs +4.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (exec_stall || exec_wsel[2]) pc_d = exec_pc_out;
  end

  assign reg_we = exec_wsel[1] && !exec_stall;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      fetch_q   <= 1'b0;
      instret_q <= '0;
      for (int i = 0; i < 32; i++) begin
        gpr_q[i] <= '0;
        fpr_q[i] <= '0;
      end
    end else begin
      fetch_q <= 1'b0;
      case (state_q)
        BOOT: begin
          fetch_q <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          if (exec_done) begin
            fetch_q <= 1'b1;
            pc_q    <= pc_d;
            if (!exec_stall) instret_q <= instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
            if (reg_we) begin
              if (exec_wsel[0])         fpr_q[exec_rd] <= exec_data;
              else if (exec_rd != 5'd0) gpr_q[exec_rd] <= exec_data;
            end
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  // No bypass: a commit at edge N becomes readable from cycle N+1.
  assign rs_data = fmode1 ? fpr_q[rs_no] : ((rs_no == 5'd0) ? 32'd0 : gpr_q[rs_no]);
  assign rt_data = fmode2 ? fpr_q[rt_no] : ((rt_no == 5'd0) ? 32'd0 : gpr_q[rt_no]);

  assign pc           = pc_q;
  assign fetch_enable = fetch_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back: commits, squashes, PC wrap, back-to-back and reset.
module tb_write_back;
  logic        clk = 1'b0;
  logic        rstn;
  logic        exec_done;
  logic [2:0]  exec_wsel;
  logic [31:0] exec_data;
  logic [4:0]  exec_rd;
  logic [31:0] exec_pc_out;
  logic        exec_stall;
  logic [4:0]  rs_no, rt_no;
  logic        fmode1, fmode2;
  logic [31:0] rs_data, rt_data, pc;
  logic        fetch_enable;
  logic [31:0] instret;

  int vectors = 0;
  int miscompares = 0;

  write_back #(.RESET_PC(32'h100), .INSTRET_W(32)) dut (
    .clk(clk), .rstn(rstn), .exec_done(exec_done), .exec_wsel(exec_wsel),
    .exec_data(exec_data), .exec_rd(exec_rd), .exec_pc_out(exec_pc_out),
    .exec_stall(exec_stall), .rs_no(rs_no), .rt_no(rt_no), .fmode1(fmode1),
    .fmode2(fmode2), .rs_data(rs_data), .rt_data(rt_data), .pc(pc),
    .fetch_enable(fetch_enable), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic set_read(input logic [4:0] a, input logic fa, input logic [4:0] b, input logic fb);
    rs_no = a; fmode1 = fa; rt_no = b; fmode2 = fb;
    #1;
  endtask

  // Presents one commit for exactly one edge; returns at the negedge after it.
  task automatic commit(input logic [2:0] w, input logic [4:0] rd, input logic [31:0] d,
                        input logic [31:0] tgt, input logic st);
    @(negedge clk);
    exec_done = 1'b1; exec_wsel = w; exec_rd = rd; exec_data = d;
    exec_pc_out = tgt; exec_stall = st;
    @(negedge clk);
    exec_done = 1'b0; exec_stall = 1'b0;
    exec_wsel = 3'b111; exec_data = 32'hA5A5A5A5; exec_rd = 5'd13;
  endtask

  task automatic test_reset;
    int bad;
    rstn = 1'b0; exec_done = 1'b0; exec_stall = 1'b0; exec_wsel = 3'b000;
    exec_data = '0; exec_rd = '0; exec_pc_out = '0;
    set_read(5'd0, 1'b0, 5'd0, 1'b0);
    repeat (3) @(negedge clk);
    // Release with a commit presented during BOOT: it must be ignored.
    rstn = 1'b1; exec_done = 1'b1; exec_wsel = 3'b010; exec_rd = 5'd3; exec_data = 32'h33;
    #1;
    vectors++;
    if (pc !== 32'h100 || fetch_enable !== 1'b0 || instret !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: pc=%h fe=%b instret=%0d, required pc=100 fe=0 instret=0", pc, fetch_enable, instret);
    end
    @(negedge clk);
    exec_done = 1'b0;
    #1;
    vectors++;
    if (fetch_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL boot_fetch: fe=%b required 1", fetch_enable);
    end
    @(negedge clk); #1;
    vectors++;
    if (fetch_enable !== 1'b0 || pc !== 32'h100 || instret !== 32'd0) begin
      miscompares++;
      $display("FAIL boot_single_pulse: fe=%b pc=%h instret=%0d, required fe=0 pc=100 instret=0", fetch_enable, pc, instret);
    end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      set_read(5'(i), 1'b0, 5'(i), 1'b1);
      if (rs_data !== 32'd0 || rt_data !== 32'd0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL reset_regs: %0d registers nonzero, required 0", bad);
    end
  endtask

  task automatic test_gpr_write;
    commit(3'b010, 5'd5, 32'hDEADBEEF, 32'h0, 1'b0);
    set_read(5'd5, 1'b0, 5'd5, 1'b1);
    vectors++;
    if (rs_data !== 32'hDEADBEEF || rt_data !== 32'd0 || pc !== 32'h104 || instret !== 32'd1 || fetch_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL gpr5_write: rs=%h rt=%h pc=%h instret=%0d fe=%b, required rs=deadbeef rt=0 pc=104 instret=1 fe=1",
               rs_data, rt_data, pc, instret, fetch_enable);
    end
    @(negedge clk); #1;
    vectors++;
    if (fetch_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_idle: fe=%b required 0", fetch_enable);
    end
    commit(3'b010, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0);
    set_read(5'd0, 1'b0, 5'd0, 1'b1);
    vectors++;
    if (rs_data !== 32'd0 || rt_data !== 32'd0 || pc !== 32'h108 || instret !== 32'd2) begin
      miscompares++;
      $display("FAIL gpr0_discard: rs=%h f0=%h pc=%h instret=%0d, required 0 0 108 2", rs_data, rt_data, pc, instret);
    end
  endtask

  task automatic test_fpr_write;
    commit(3'b011, 5'd0, 32'h3F800000, 32'h0, 1'b0);
    set_read(5'd0, 1'b0, 5'd0, 1'b1);
    vectors++;
    if (rt_data !== 32'h3F800000 || rs_data !== 32'd0 || pc !== 32'h10C || instret !== 32'd3) begin
      miscompares++;
      $display("FAIL fpr0_write: f0=%h r0=%h pc=%h instret=%0d, required 3f800000 0 10c 3", rt_data, rs_data, pc, instret);
    end
  endtask

  task automatic test_jal;
    commit(3'b110, 5'd31, 32'h24, 32'h400, 1'b0);
    set_read(5'd31, 1'b0, 5'd31, 1'b1);
    vectors++;
    if (rs_data !== 32'h24 || rt_data !== 32'd0 || pc !== 32'h400 || instret !== 32'd4 || fetch_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL jal: r31=%h f31=%h pc=%h instret=%0d fe=%b, required 24 0 400 4 1", rs_data, rt_data, pc, instret, fetch_enable);
    end
  endtask

  task automatic test_squash;
    commit(3'b010, 5'd7, 32'h55, 32'h800, 1'b1);
    set_read(5'd7, 1'b0, 5'd7, 1'b1);
    vectors++;
    if (rs_data !== 32'd0 || rt_data !== 32'd0 || pc !== 32'h800 || instret !== 32'd4 || fetch_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL squash: r7=%h f7=%h pc=%h instret=%0d fe=%b, required 0 0 800 4 1", rs_data, rt_data, pc, instret, fetch_enable);
    end
  endtask

  task automatic test_pc_wrap;
    commit(3'b100, 5'd2, 32'h77, 32'hFFFFFFFC, 1'b0);
    vectors++;
    if (pc !== 32'hFFFFFFFC || instret !== 32'd5) begin
      miscompares++;
      $display("FAIL redirect_only: pc=%h instret=%0d, required fffffffc 5", pc, instret);
    end
    commit(3'b000, 5'd2, 32'h77, 32'h1234, 1'b0);
    set_read(5'd2, 1'b0, 5'd2, 1'b1);
    vectors++;
    if (pc !== 32'h0 || instret !== 32'd6 || rs_data !== 32'd0 || rt_data !== 32'd0) begin
      miscompares++;
      $display("FAIL pc_wrap: pc=%h instret=%0d r2=%h f2=%h, required 0 6 0 0", pc, instret, rs_data, rt_data);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    exec_done = 1'b1; exec_stall = 1'b0; exec_wsel = 3'b010; exec_rd = 5'd1;
    exec_data = 32'h11; exec_pc_out = 32'h0;
    @(negedge clk);
    exec_wsel = 3'b011; exec_rd = 5'd2; exec_data = 32'h22;
    #1;
    vectors++;
    if (fetch_enable !== 1'b1 || pc !== 32'h4) begin
      miscompares++;
      $display("FAIL b2b_first: fe=%b pc=%h, required 1 4", fetch_enable, pc);
    end
    @(negedge clk);
    exec_done = 1'b0;
    set_read(5'd1, 1'b0, 5'd2, 1'b1);
    vectors++;
    if (rs_data !== 32'h11 || rt_data !== 32'h22 || pc !== 32'h8 || instret !== 32'd8 || fetch_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second: r1=%h f2=%h pc=%h instret=%0d fe=%b, required 11 22 8 8 1", rs_data, rt_data, pc, instret, fetch_enable);
    end
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    rstn = 1'b0; exec_done = 1'b1; exec_wsel = 3'b010; exec_rd = 5'd9; exec_data = 32'h99;
    exec_stall = 1'b0;
    @(negedge clk);
    exec_done = 1'b0;
    set_read(5'd9, 1'b0, 5'd31, 1'b0);
    vectors++;
    if (pc !== 32'h100 || instret !== 32'd0 || fetch_enable !== 1'b0 || rs_data !== 32'd0 || rt_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid_op: pc=%h instret=%0d fe=%b r9=%h r31=%h, required 100 0 0 0 0", pc, instret, fetch_enable, rs_data, rt_data);
    end
    rstn = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if (fetch_enable !== 1'b1 || pc !== 32'h100) begin
      miscompares++;
      $display("FAIL reboot_fetch: fe=%b pc=%h, required 1 100", fetch_enable, pc);
    end
  endtask

  initial begin
    test_reset;
    test_gpr_write;
    test_fpr_write;
    test_jal;
    test_squash;
    test_pc_wrap;
    test_back_to_back;
    test_reset_mid_op;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/write_back.md
Name: write_back

Overview:
- Commit stage directly downstream of the execute stage.
- Consumes exec's done/wselector/data/rd/pc_out outputs.
- Commits results into the integer register file (GPR) and the float register file (FPR), 32×32 each.
- Owns the architectural PC and re-arms instruction fetch after every committed or squashed instruction.
- Provides the register read ports that feed the operand inputs of the execute stage.

Parameters:
- RESET_PC, 32'h0, PC value loaded on reset.
- INSTRET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- exec_done  in  1  one-cycle pulse: exec finished (or squashed) an instruction
- exec_wsel  in  3  [2]=PC redirect, [1]=register write, [0]=bank (0 GPR, 1 FPR)
- exec_data  in  32  write-back value
- exec_rd  in  5  destination register number
- exec_pc_out  in  32  redirect / branch target
- exec_stall  in  1  with exec_done: instruction squashed after a taken redirect
- rs_no  in  5  read port A register number
- rt_no  in  5  read port B register number
- fmode1  in  1  port A bank select (1 = FPR)
- fmode2  in  1  port B bank select (1 = FPR)
- rs_data  out  32  port A data, combinational
- rt_data  out  32  port B data, combinational
- pc  out  32  current fetch PC
- fetch_enable  out  1  one-cycle pulse: fetch at pc
- instret  out  INSTRET_W  count of committed (non-squashed) instructions

Behaviour:
- Reset (rstn=0 at a clk edge):
  - pc=RESET_PC, fetch_enable=0, instret=0.
  - All 64 registers = 0.
  - State = BOOT.
- States:
  - BOOT: first edge with rstn=1 → fetch_enable=1 for one cycle, state → RUN.
  - RUN: persistent.
  - exec_done in BOOT is ignored.
- Commit happens at the edge where exec_done=1 in RUN; all effects are visible the following cycle (latency 1).
  - Register write when exec_wsel[1]=1 and exec_stall=0:
    - exec_wsel[0]=0 → GPR[exec_rd] ← exec_data. GPR write to r0 is discarded.
    - exec_wsel[0]=1 → FPR[exec_rd] ← exec_data. f0 is writable.
  - PC update:
    - exec_stall=1 → pc ← exec_pc_out.
    - Else exec_wsel[2]=1 → pc ← exec_pc_out.
    - Else pc ← pc+4, modulo 2^32 (32'hFFFFFFFC wraps to 0).
  - fetch_enable=1 for exactly one cycle on every commit, including squashes.
  - instret increments (wrapping) only when exec_stall=0.
  - exec_wsel=3'b000 (stores, OUT, branches not taken via redirect bits) → PC advance only.
  - exec_wsel=3'b110 (JAL/JALR) → both the register write and the redirect in the same commit.
- exec_wsel/exec_data/exec_rd/exec_pc_out are sampled only when exec_done=1; otherwise they are don't-care.
- Read ports:
  - rs_data = fmode1 ? FPR[rs_no] : GPR[rs_no]; rt_data likewise with fmode2/rt_no.
  - GPR[0] always reads 0.
  - No internal bypass: a write at edge N is visible to reads from cycle N+1. Execute-stage forwarding covers the gap.
- exec_done asserted two cycles in a row: each is a separate commit; no merging.
- Reset mid-operation: pending commit is lost; state → BOOT; pc → RESET_PC.

Test Plan:
- Reset release with RESET_PC=32'h100 → pc=32'h100, one fetch_enable pulse one cycle after release, instret=0, rs_data=rt_data=0 for all registers.
- exec_done, wsel=3'b010, rd=5, data=32'hDEADBEEF → next cycle rs_no=5/fmode1=0 reads DEADBEEF, pc=+4, instret=1, fetch_enable pulse. rd=0 repeat → GPR0 still reads 0.
- wsel=3'b011, rd=0, data=32'h3F800000 → FPR0 reads 3F800000 with fmode2=1; GPR0 unchanged (0).
- wsel=3'b110, rd=31, data=32'h24, pc_out=32'h400 → GPR31=32'h24, pc=32'h400.
- exec_done with exec_stall=1, pc_out=32'h400, wsel=3'b010 → no register write, pc=32'h400, instret unchanged, fetch_enable pulses.
- pc=32'hFFFFFFFC, wsel=000 → pc=0. Assert rstn=0 in the same cycle as exec_done → pc=RESET_PC, no register write.
